aes_share_sequencer: RTL
========================

AES_SHARE_SEQUENCER -- requirements
Module: aes_share_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYC, default 2048: max cycles in RUN before timeout.
REQ-002 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value; must be nonzero.
REQ-003 Port clk  in  1  single clock; every flop is rising-edge.
REQ-004 Port rstn  in  1  asynchronous active-low reset.
REQ-005 Ports in_valid in 1 / in_ready out 1: block-input handshake; transfer on in_valid&in_ready.
REQ-006 Ports pt_sh0, pt_sh1, key_sh0, key_sh1  in  128 each  plaintext and key shares; bits [127:120] are byte 0.
REQ-007 Ports seed_load in 1 / seed in 16: synchronous LFSR reseed.
REQ-008 Ports out_valid out 1 / out_ready in 1: result handshake.
REQ-009 Ports ct_sh0, ct_sh1  out  128 each  ciphertext shares; out_err  out  1  timeout flag.
REQ-010 Port busy  out  1  high in any state except IDLE.
REQ-011 Ports core_plain0/1, core_key0/1  out  8 each  byte lanes to the masked AES core.
REQ-012 Port core_pk_valid  out  1  core load strobe; core_random  out  4  fresh mask bits per cycle.
REQ-013 Ports core_cipher0/1  in  8 each / core_done  in  1  core result bytes and done.

Function
REQ-014 The FSM SHALL have the states IDLE, LOAD, RUN, COLLECT and HOLD, encoded in 3 bits.
REQ-015 IDLE: in_ready=1; on transfer, register all four 128-bit inputs, clear byte counter, go to LOAD next cycle.
REQ-016 LOAD: 16 consecutive cycles, core_pk_valid=1, lanes carry byte[cnt] of each registered share, cnt 0..15; after cnt=15 go to RUN.
REQ-017 RUN: core_pk_valid=0; wait for core_done; on core_done=1, capture byte 0 of core_cipher0/1 that same cycle and go to COLLECT with cnt=1.
REQ-018 COLLECT: capture core_cipher0/1 into byte[cnt] each cycle for cnt 1..15 without checking core_done; after byte 15 go to HOLD.
REQ-019 HOLD: out_valid=1, ct_sh0/ct_sh1/out_err stable; on out_ready go to IDLE; a new input is accepted no earlier than the next IDLE cycle.
REQ-020 Timeout: RUN cycle counter reaching TIMEOUT_CYC-1 without core_done SHALL force HOLD with out_err=1 and ct_sh0/ct_sh1 = 0.
REQ-021 out_err SHALL be 0 for every non-timeout result.
REQ-022 core_random SHALL be LFSR[3:0], advanced every cycle in LOAD, RUN and COLLECT, frozen otherwise.
REQ-023 LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, shifting left.
REQ-024 A seed_load with seed=0 SHALL load LFSR_SEED instead.
REQ-025 seed_load SHALL take effect only in IDLE; outside IDLE it is ignored.
REQ-026 seed_load and an input transfer in the same IDLE cycle: both take effect, and the first LOAD cycle uses the new seed.
REQ-027 Unmasked data SHALL never be formed: shares are never XORed together inside this block.
REQ-028 Core lanes SHALL drive 0 outside LOAD.

Reset
REQ-029 On rstn=0, asynchronously: state=IDLE, counters=0, LFSR=LFSR_SEED, all data registers=0.
REQ-030 Reset output values: in_ready=1, out_valid=0, out_err=0, busy=0, core_pk_valid=0, ct_sh0=0, ct_sh1=0.
REQ-031 Reset asserted mid-LOAD, RUN or COLLECT SHALL abort the operation with no out_valid pulse afterwards.

Structure
REQ-032 Package aes_seq_pkg SHALL hold the state enum, NBYTES=16, the byte-select function and the LFSR tap constant.
REQ-033 The LFSR SHALL be one sub-module, aes_seq_lfsr16 (ports: clk, rstn, en, load, seed, q).

Verification
REQ-034 Scenario FIPS-197: key 000102..0f, pt 00112233..ff, sh1 random, sh0 = value^sh1 -> ct_sh0^ct_sh1 = 69c4e0d86a7b0430d8cdb78070b4c55a, out_err=0.
REQ-035 Scenario load timing: core_pk_valid high exactly 16 cycles; core_plain0 sequence equals pt_sh0 bytes 0..15 in order.
REQ-036 Scenario timeout: core_done held 0, TIMEOUT_CYC=64 -> HOLD 65 cycles after the last LOAD cycle, out_err=1, ct=0.
REQ-037 Scenario backpressure: out_ready low 10 cycles -> out_valid and ct stable; in_ready=0 until the IDLE cycle after acceptance.
REQ-038 Scenario reset in COLLECT at cnt=7 -> immediate IDLE, out_valid never asserts, LFSR=LFSR_SEED.
REQ-039 Scenario seed: seed_load with seed=0 in IDLE, then start -> first core_random equals LFSR_SEED[3:0].

Source files
------------

// File: rtl/aes_seq_pkg.sv
// Shared types, sizes and byte helpers for the AES share sequencer.
package aes_seq_pkg;

    localparam int unsigned NBYTES = 16;
    localparam int unsigned BLK_W  = 8 * NBYTES;
    localparam int unsigned CNT_W  = 4;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_COLLECT = 3'd3,
        ST_HOLD    = 3'd4
    } seq_state_e;

    // Byte idx of a block; byte 0 sits in the most significant lane.
    function automatic logic [7:0] sel_byte(input logic [BLK_W-1:0] blk,
                                            input logic [CNT_W-1:0] idx);
        logic [BLK_W-1:0] sh;
        sh = blk << {idx, 3'b000};
        return sh[BLK_W-1 -: 8];
    endfunction

    // Replace byte idx of a block, leaving the other bytes untouched.
    function automatic logic [BLK_W-1:0] put_byte(input logic [BLK_W-1:0] blk,
                                                  input logic [CNT_W-1:0] idx,
                                                  input logic [7:0]       b);
        logic [BLK_W-1:0] mask;
        logic [BLK_W-1:0] val;
        mask = {8'hFF, {(BLK_W-8){1'b0}}} >> {idx, 3'b000};
        val  = {b,     {(BLK_W-8){1'b0}}} >> {idx, 3'b000};
        return (blk & ~mask) | val;
    endfunction

endpackage

// File: rtl/aes_seq_lfsr16.sv
// 16-bit left-shifting Fibonacci LFSR supplying fresh mask bits.
module aes_seq_lfsr16
    import aes_seq_pkg::*;
#(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int unsigned OUT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             load,
    input  logic [15:0]      seed,
    output logic [OUT_W-1:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    // Reseed wins over stepping; an all-zero seed would lock up, so it maps to SEED.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = (seed == 16'h0000) ? SEED : seed;
        end else if (en) begin
            q_d = {q_q[14:0], ^(q_q & LFSR_TAPS)};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q[OUT_W-1:0];

endmodule

// File: rtl/aes_share_sequencer.sv
// Feeds masked plaintext/key shares bytewise into a masked AES core and
// gathers the masked ciphertext bytes back; the two shares never meet here.
module aes_share_sequencer
    import aes_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 2048,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] pt_sh0,
    input  logic [127:0] pt_sh1,
    input  logic [127:0] key_sh0,
    input  logic [127:0] key_sh1,
    input  logic         seed_load,
    input  logic [15:0]  seed,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ct_sh0,
    output logic [127:0] ct_sh1,
    output logic         out_err,
    output logic         busy,
    output logic [7:0]   core_plain0,
    output logic [7:0]   core_plain1,
    output logic [7:0]   core_key0,
    output logic [7:0]   core_key1,
    output logic         core_pk_valid,
    output logic [3:0]   core_random,
    input  logic [7:0]   core_cipher0,
    input  logic [7:0]   core_cipher1,
    input  logic         core_done
);

    localparam int unsigned       RUN_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NBYTES - 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;

    logic [BLK_W-1:0] pt0_q, pt0_d, pt1_q, pt1_d;
    logic [BLK_W-1:0] key0_q, key0_d, key1_q, key1_d;
    logic [BLK_W-1:0] ct0_q, ct0_d, ct1_q, ct1_d;
    logic             err_q, err_d;

    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             pk_valid_q, pk_valid_d;
    logic [7:0]       plain0_q, plain0_d, plain1_q, plain1_d;
    logic [7:0]       lkey0_q, lkey0_d, lkey1_q, lkey1_d;

    logic             xfer_c;
    logic             lfsr_en_c;
    logic             lfsr_load_c;

    assign xfer_c      = in_valid & in_ready_q;
    assign lfsr_en_c   = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_COLLECT);
    assign lfsr_load_c = seed_load && (state_q == ST_IDLE);

    // Mask source; advances only while the core is being fed or is computing.
    aes_seq_lfsr16 #(
        .SEED  (LFSR_SEED),
        .OUT_W (4)
    ) u_lfsr (
        .clk  (clk),
        .rstn (rstn),
        .en   (lfsr_en_c),
        .load (lfsr_load_c),
        .seed (seed),
        .q    (core_random)
    );

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        run_cnt_d = run_cnt_q;
        pt0_d     = pt0_q;
        pt1_d     = pt1_q;
        key0_d    = key0_q;
        key1_d    = key1_q;
        ct0_d     = ct0_q;
        ct1_d     = ct1_q;
        err_d     = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (xfer_c) begin
                    state_d   = ST_LOAD;
                    cnt_d     = '0;
                    run_cnt_d = '0;
                    pt0_d     = pt_sh0;
                    pt1_d     = pt_sh1;
                    key0_d    = key_sh0;
                    key1_d    = key_sh1;
                    ct0_d     = '0;
                    ct1_d     = '0;
                    err_d     = 1'b0;
                end
            end
            ST_LOAD: begin
                if (cnt_q == CNT_LAST) begin
                    state_d   = ST_RUN;
                    cnt_d     = '0;
                    run_cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                // Done takes priority over a timeout landing in the same cycle.
                if (core_done) begin
                    ct0_d   = put_byte(ct0_q, '0, core_cipher0);
                    ct1_d   = put_byte(ct1_q, '0, core_cipher1);
                    state_d = ST_COLLECT;
                    cnt_d   = CNT_W'(1);
                end else if (run_cnt_q == RUN_LAST) begin
                    state_d = ST_HOLD;
                    err_d   = 1'b1;
                    ct0_d   = '0;
                    ct1_d   = '0;
                end else begin
                    run_cnt_d = run_cnt_q + RUN_W'(1);
                end
            end
            ST_COLLECT: begin
                // The core streams one byte per cycle after done; no handshake here.
                ct0_d = put_byte(ct0_q, cnt_q, core_cipher0);
                ct1_d = put_byte(ct1_q, cnt_q, core_cipher1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        out_valid_d = (state_d == ST_HOLD);
        pk_valid_d  = (state_d == ST_LOAD);

        // Core lanes are quiet outside LOAD so no share residue leaks to the core.
        plain0_d = '0;
        plain1_d = '0;
        lkey0_d  = '0;
        lkey1_d  = '0;
        if (state_d == ST_LOAD) begin
            plain0_d = sel_byte(pt0_d, cnt_d);
            plain1_d = sel_byte(pt1_d, cnt_d);
            lkey0_d  = sel_byte(key0_d, cnt_d);
            lkey1_d  = sel_byte(key1_d, cnt_d);
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            run_cnt_q   <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            pk_valid_q  <= 1'b0;
            plain0_q    <= '0;
            plain1_q    <= '0;
            lkey0_q     <= '0;
            lkey1_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_cnt_q   <= run_cnt_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            pk_valid_q  <= pk_valid_d;
            plain0_q    <= plain0_d;
            plain1_q    <= plain1_d;
            lkey0_q     <= lkey0_d;
            lkey1_q     <= lkey1_d;
        end
    end

    // Share and result registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pt0_q  <= '0;
            pt1_q  <= '0;
            key0_q <= '0;
            key1_q <= '0;
            ct0_q  <= '0;
            ct1_q  <= '0;
        end else begin
            pt0_q  <= pt0_d;
            pt1_q  <= pt1_d;
            key0_q <= key0_d;
            key1_q <= key1_d;
            ct0_q  <= ct0_d;
            ct1_q  <= ct1_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign busy          = busy_q;
    assign out_valid     = out_valid_q;
    assign out_err       = err_q;
    assign ct_sh0        = ct0_q;
    assign ct_sh1        = ct1_q;
    assign core_pk_valid = pk_valid_q;
    assign core_plain0   = plain0_q;
    assign core_plain1   = plain1_q;
    assign core_key0     = lkey0_q;
    assign core_key1     = lkey1_q;

endmodule
